// File: rtl/perf_pkg.sv
// Shared types for the performance-monitoring unit: FSM state encoding and
// the dump-index width helper.
package perf_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DUMP,
    DONE
  } perf_state_e;

  // Width needed to address the cycle counter plus num_evt event counters.
  function automatic int idx_w(input int num_evt);
    return (num_evt < 1) ? 1 : $clog2(num_evt + 1);
  endfunction

endpackage

// File: rtl/perf_sat_counter.sv
// Saturating event counter with sticky overflow flag. Exposes the value the
// counter takes at the coming edge so a consumer can capture it in lockstep.
module perf_sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt_nxt,
  output logic             o_ovf
);

  logic [CNT_W-1:0] cnt_q;
  logic             at_max;

  assign at_max = &cnt_q;

  // NOTE: every variable driven in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    o_cnt_nxt = cnt_q;
    if (i_inc && !at_max) o_cnt_nxt = cnt_q + CNT_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt_q <= '0;
      o_ovf <= 1'b0;
    end else begin
      cnt_q <= o_cnt_nxt;
      if (i_inc && at_max) o_ovf <= 1'b1;
    end
  end

endmodule

// File: rtl/perf_counter_unit.sv
// Performance-monitoring unit: counts cycles and event strobes between two
// debug-PC matches, then streams the frozen counters over a valid/ready port.
module perf_counter_unit
  import perf_pkg::*;
#(
  parameter  int          NUM_EVT  = 4,
  parameter  int          CNT_W    = 32,
  parameter  logic [31:0] START_PC = 32'h0000_0000,
  parameter  logic [31:0] STOP_PC  = 32'h0000_001c,
  localparam int          IDX_W    = idx_w(NUM_EVT)
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [31:0]        i_pc_debug,
  input  logic               i_insn_vld,
  input  logic [NUM_EVT-1:0] i_evt,
  input  logic               i_dump_rdy,
  output logic               o_dump_vld,
  output logic [IDX_W-1:0]   o_dump_idx,
  output logic [CNT_W-1:0]   o_dump_data,
  output logic [NUM_EVT:0]   o_ovf,
  output logic               o_busy,
  output logic               o_done
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_EVT);

  perf_state_e      state_q, state_d;
  logic             start_hit, stop_hit, cnt_en, beat_acc;
  logic [NUM_EVT:0] inc;
  logic [IDX_W-1:0] idx_nxt;
  logic [CNT_W-1:0] cnt_nxt [NUM_EVT+1];

  assign start_hit = i_insn_vld && (i_pc_debug == START_PC);
  assign stop_hit  = i_insn_vld && (i_pc_debug == STOP_PC);
  assign beat_acc  = o_dump_vld && i_dump_rdy;
  assign idx_nxt   = o_dump_idx + IDX_W'(1);

  // IDLE only looks at start_hit, so equal START_PC/STOP_PC opens on the first hit.
  always_comb begin
    state_d = state_q;
    cnt_en  = 1'b0;
    case (state_q)
      IDLE: if (start_hit) begin
        state_d = RUN;
        cnt_en  = 1'b1;
      end
      RUN: begin
        cnt_en = 1'b1;
        if (stop_hit) state_d = DUMP;
      end
      DUMP:    if (beat_acc && (o_dump_idx == LAST_IDX)) state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  assign inc = {i_evt & {NUM_EVT{cnt_en}}, cnt_en};

  for (genvar k = 0; k <= NUM_EVT; k++) begin : g_cnt
    perf_sat_counter #(.CNT_W(CNT_W)) u_cnt (
      .i_clk     (i_clk),
      .i_reset   (i_reset),
      .i_inc     (inc[k]),
      .o_cnt_nxt (cnt_nxt[k]),
      .o_ovf     (o_ovf[k])
    );
  end

  // The first beat captures the cycle counter's post-edge value so the
  // stop_hit cycle is included; later beats read the frozen counters.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= IDLE;
      o_dump_vld  <= 1'b0;
      o_dump_idx  <= '0;
      o_dump_data <= '0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
    end else begin
      state_q <= state_d;
      o_busy  <= (state_d == RUN);
      o_done  <= (state_d == DONE);
      if ((state_q == RUN) && stop_hit) begin
        o_dump_vld  <= 1'b1;
        o_dump_idx  <= '0;
        o_dump_data <= cnt_nxt[0];
      end else if ((state_q == DUMP) && beat_acc) begin
        if (o_dump_idx == LAST_IDX) begin
          o_dump_vld <= 1'b0;
        end else begin
          o_dump_idx  <= idx_nxt;
          o_dump_data <= cnt_nxt[idx_nxt];
        end
      end
    end
  end

endmodule
